// File: rtl/ps2_keypad_decoder.sv
// PS/2 set-2 byte stream to card-entry key events (digit/enter/backspace/clear).
// Ports: CLOCK_50, reset (sync, high), scancode/scancode_valid in;
//   number, digit, *_strobe, held_valid out. Macro PS2_NUMPAD_EN adds numpad keys.
module ps2_keypad_decoder #(
  parameter int PREFIX_TIMEOUT = 50000,
  parameter int CNT_W          = 16
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] scancode,
  input  logic       scancode_valid,
  output logic [9:0] number,
  output logic [3:0] digit,
  output logic       digit_strobe,
  output logic       enter_strobe,
  output logic       backspace_strobe,
  output logic       clear_strobe,
  output logic       held_valid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK
  } state_t;

  typedef enum logic [2:0] {
    K_NONE,
    K_DIG,
    K_ENT,
    K_BSP,
    K_ESC
  } kind_t;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(PREFIX_TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [8:0]       held_code;

  logic       ext;
  logic [8:0] code;
  kind_t      kind;
  logic [3:0] dval;
  logic       is_f0;
  logic       is_e0;
  logic       make_ev;
  logic       brk_ev;
  logic       fire;

  assign is_f0 = scancode == 8'hF0;
  assign is_e0 = scancode == 8'hE0;
  assign ext   = (state == S_EXT) || (state == S_EXT_BRK);
  assign code  = {ext, scancode};

  // Make: non-prefix byte in IDLE, or non-F0 byte after E0.
  assign make_ev = scancode_valid &&
    (((state == S_IDLE) && !is_f0 && !is_e0) ||
     ((state == S_EXT) && !is_f0));
  assign brk_ev = scancode_valid &&
    ((state == S_BRK) || (state == S_EXT_BRK));

  // A repeat of the held key is typematic and stays silent.
  assign fire = make_ev && (kind != K_NONE) &&
    !(held_valid && (held_code == code));

  always_comb begin
    kind = K_NONE;
    dval = 4'd0;
    case (code)
      9'h045: begin kind = K_DIG; dval = 4'd0; end
      9'h016: begin kind = K_DIG; dval = 4'd1; end
      9'h01E: begin kind = K_DIG; dval = 4'd2; end
      9'h026: begin kind = K_DIG; dval = 4'd3; end
      9'h025: begin kind = K_DIG; dval = 4'd4; end
      9'h02E: begin kind = K_DIG; dval = 4'd5; end
      9'h036: begin kind = K_DIG; dval = 4'd6; end
      9'h03D: begin kind = K_DIG; dval = 4'd7; end
      9'h03E: begin kind = K_DIG; dval = 4'd8; end
      9'h046: begin kind = K_DIG; dval = 4'd9; end
      9'h05A: kind = K_ENT;
      9'h066: kind = K_BSP;
      9'h076: kind = K_ESC;
`ifdef PS2_NUMPAD_EN
      9'h070: begin kind = K_DIG; dval = 4'd0; end
      9'h069: begin kind = K_DIG; dval = 4'd1; end
      9'h072: begin kind = K_DIG; dval = 4'd2; end
      9'h07A: begin kind = K_DIG; dval = 4'd3; end
      9'h06B: begin kind = K_DIG; dval = 4'd4; end
      9'h073: begin kind = K_DIG; dval = 4'd5; end
      9'h074: begin kind = K_DIG; dval = 4'd6; end
      9'h06C: begin kind = K_DIG; dval = 4'd7; end
      9'h075: begin kind = K_DIG; dval = 4'd8; end
      9'h07D: begin kind = K_DIG; dval = 4'd9; end
      9'h15A: kind = K_ENT;
`endif
      default: begin
        kind = K_NONE;
        dval = 4'd0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state            <= S_IDLE;
      cnt              <= '0;
      held_code        <= '0;
      held_valid       <= 1'b0;
      number           <= '0;
      digit            <= '0;
      digit_strobe     <= 1'b0;
      enter_strobe     <= 1'b0;
      backspace_strobe <= 1'b0;
      clear_strobe     <= 1'b0;
    end else begin
      digit_strobe     <= 1'b0;
      enter_strobe     <= 1'b0;
      backspace_strobe <= 1'b0;
      clear_strobe     <= 1'b0;

      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (scancode_valid) begin
            if (is_f0)      state <= S_BRK;
            else if (is_e0) state <= S_EXT;
          end
        end
        default: begin
          // A byte beats a timeout landing in the same cycle.
          if (scancode_valid) begin
            cnt <= '0;
            if ((state == S_EXT) && is_f0) state <= S_EXT_BRK;
            else                           state <= S_IDLE;
          end else if (cnt >= TO_LAST) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase

      if (fire) begin
        held_code  <= code;
        held_valid <= 1'b1;
        unique case (1'b1)
          kind == K_DIG: begin
            digit_strobe <= 1'b1;
            digit        <= dval;
            number       <= 10'd1 << dval;
          end
          kind == K_ENT: enter_strobe     <= 1'b1;
          kind == K_BSP: backspace_strobe <= 1'b1;
          kind == K_ESC: begin
            clear_strobe <= 1'b1;
            number       <= '0;
          end
          default: ;
        endcase
      end

      if (brk_ev && (held_code == code)) held_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_keypad_decoder.sv
// Directed bench for ps2_keypad_decoder with a shortened prefix timeout.
// Build with +define+PS2_NUMPAD_EN to check the numpad expectations.
module tb_ps2_keypad_decoder;

  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] scancode;
  logic       scancode_valid;
  logic [9:0] number;
  logic [3:0] digit;
  logic       digit_strobe;
  logic       enter_strobe;
  logic       backspace_strobe;
  logic       clear_strobe;
  logic       held_valid;

  int n_chk = 0;
  int n_fail = 0;
  int dcnt = 0;
  int ecnt = 0;
  int bcnt = 0;
  int ccnt = 0;
  int multi = 0;
  int order_ok = 1;
  int last_kind = 0;

  ps2_keypad_decoder #(.PREFIX_TIMEOUT(TO), .CNT_W(8)) dut (
    .CLOCK_50        (clk),
    .reset           (reset),
    .scancode        (scancode),
    .scancode_valid  (scancode_valid),
    .number          (number),
    .digit           (digit),
    .digit_strobe    (digit_strobe),
    .enter_strobe    (enter_strobe),
    .backspace_strobe(backspace_strobe),
    .clear_strobe    (clear_strobe),
    .held_valid      (held_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (digit_strobe)     dcnt++;
    if (enter_strobe)     ecnt++;
    if (backspace_strobe) bcnt++;
    if (clear_strobe)     ccnt++;
    if (32'(digit_strobe) + 32'(enter_strobe) +
        32'(backspace_strobe) + 32'(clear_strobe) > 1)
      multi++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    scancode = b;
    scancode_valid = 1'b1;
    @(negedge clk);
    scancode_valid = 1'b0;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    scancode = 8'h00;
    scancode_valid = 1'b0;
    idle(3);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_number", 32'(number), 0);
    chk("rst_digit", 32'(digit), 0);
    chk("rst_held", 32'(held_valid), 0);
    chk("rst_strobes", {digit_strobe, enter_strobe,
        backspace_strobe, clear_strobe}, 0);

    // make, break of digit 2
    send(8'h1E);
    chk("d2_strobe", 32'(digit_strobe), 1);
    chk("d2_digit", 32'(digit), 2);
    chk("d2_number", 32'(number), 32'h004);
    chk("d2_held", 32'(held_valid), 1);
    idle(1);
    chk("d2_strobe_len", 32'(digit_strobe), 0);
    send(8'hF0);
    chk("d2_held_mid", 32'(held_valid), 1);
    send(8'h1E);
    chk("d2_released", 32'(held_valid), 0);
    chk("d2_count", 32'(dcnt), 1);

    // typematic repeat of 8
    send(8'h3E);
    send(8'h3E);
    send(8'h3E);
    chk("rep_count", 32'(dcnt), 2);
    send(8'hF0);
    send(8'h3E);
    chk("rep_released", 32'(held_valid), 0);
    send(8'h3E);
    chk("rep_count2", 32'(dcnt), 3);
    chk("rep_digit", 32'(digit), 8);
    chk("rep_number", 32'(number), 32'h100);

    // another key replaces the held one
    send(8'h16);
    chk("repl_count", 32'(dcnt), 4);
    chk("repl_digit", 32'(digit), 1);
    chk("repl_number", 32'(number), 32'h002);
    send(8'hF0);
    send(8'h16);
    chk("repl_released", 32'(held_valid), 0);

    // break of a non-held key is ignored
    send(8'h45);
    send(8'hF0);
    send(8'h16);
    chk("nh_break_held", 32'(held_valid), 1);
    send(8'h45);
    chk("nh_repeat", 32'(dcnt), 5);
    send(8'hF0);
    send(8'h45);
    chk("nh_released", 32'(held_valid), 0);

    // prefix followed in time stays a break
    send(8'h16);
    send(8'hF0);
    idle(TO - 5);
    send(8'h16);
    chk("pre_to_break", 32'(held_valid), 0);
    chk("pre_to_count", 32'(dcnt), 6);

    // prefix timeout: following byte is a make
    send(8'hF0);
    idle(TO + 5);
    send(8'h45);
    chk("to_strobe", 32'(digit_strobe), 1);
    chk("to_digit", 32'(digit), 0);
    chk("to_number", 32'(number), 32'h001);
    send(8'hF0);
    send(8'h45);

    // commands
    send(8'h26);
    send(8'hF0);
    send(8'h26);
    send(8'h5A);
    chk("ent_strobe", 32'(enter_strobe), 1);
    send(8'hF0);
    send(8'h5A);
    send(8'h66);
    chk("bsp_strobe", 32'(backspace_strobe), 1);
    send(8'hF0);
    send(8'h66);
    chk("pre_esc_number", 32'(number), 32'h008);
    send(8'h76);
    chk("esc_strobe", 32'(clear_strobe), 1);
    chk("esc_number", 32'(number), 0);
    chk("esc_digit", 32'(digit), 3);
    chk("cmd_counts", {8'(ecnt), 8'(bcnt), 8'(ccnt)}, 32'h010101);
    send(8'hF0);
    send(8'h76);

    // extended keys and numpad
    send(8'hE0);
    send(8'h16);
    chk("ext_ignored", 32'(dcnt), 8);
    send(8'hE0);
    send(8'h5A);
`ifdef PS2_NUMPAD_EN
    chk("kp_enter", 32'(ecnt), 2);
`else
    chk("kp_enter", 32'(ecnt), 1);
`endif
    send(8'hE0);
    send(8'hF0);
    send(8'h5A);
    chk("kp_enter_rel", 32'(held_valid), 0);
    send(8'h7D);
`ifdef PS2_NUMPAD_EN
    chk("kp_9_digit", 32'(digit), 9);
    chk("kp_9_count", 32'(dcnt), 9);
`else
    chk("kp_9_digit", 32'(digit), 3);
    chk("kp_9_count", 32'(dcnt), 8);
`endif
    send(8'hF0);
    send(8'h7D);

    // reset mid-sequence
    send(8'hE0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_strobes", {digit_strobe, enter_strobe,
        backspace_strobe, clear_strobe}, 0);
    send(8'hF0);
    send(8'h16);
    idle(2);
    chk("mid_rst_number", 32'(number), 0);
    chk("mid_rst_digit", 32'(digit), 0);
    chk("mid_rst_held", 32'(held_valid), 0);
`ifdef PS2_NUMPAD_EN
    chk("mid_rst_counts", {8'(dcnt), 8'(ecnt)}, 32'h0902);
`else
    chk("mid_rst_counts", {8'(dcnt), 8'(ecnt)}, 32'h0801);
`endif
    chk("one_hot_strobes", 32'(multi), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_keypad_decoder.md
Name: ps2_keypad_decoder

Overview:
Converts the raw PS/2 set-2 byte stream into card-entry key events. It sits between the PS/2 byte receiver and the digit-entry / Luhn control logic.
- Handles make, break (F0) and extended (E0) prefixes, and suppresses typematic auto-repeat.
- Emits single-cycle strobes for digit, enter, backspace and clear.
- Holds a one-hot level for the last digit selected.

Parameters:
- PREFIX_TIMEOUT, 50000, cycles allowed between a prefix byte (E0/F0) and the byte that follows it before the sequence is abandoned.
- CNT_W, 16, width of the timeout counter; must satisfy 2^CNT_W > PREFIX_TIMEOUT.

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- scancode  in  8  received PS/2 byte.
- scancode_valid  in  1  one-cycle qualifier for scancode.
- number  out  10  one-hot level of the last accepted digit (bit n = digit n); 0 means none.
- digit  out  4  binary value of the last accepted digit.
- digit_strobe  out  1  one-cycle pulse when a digit is accepted.
- enter_strobe  out  1  one-cycle pulse on an Enter make.
- backspace_strobe  out  1  one-cycle pulse on a Backspace make.
- clear_strobe  out  1  one-cycle pulse on an Esc make; also zeroes number.
- held_valid  out  1  a recognised key is currently held down.

Behaviour:
- Reset, sampled on a clock edge while reset=1, sets:
  - state=IDLE, number=0, digit=0, all strobes 0, held_valid=0, held code cleared, timeout counter=0.
- Byte handling: bytes are consumed only when scancode_valid=1. All strobes are registered.
  - A strobe is high in the cycle after the final byte of a make sequence, for exactly 1 cycle.
- Digit key map (base): 45=0, 16=1, 1E=2, 26=3, 25=4, 2E=5, 36=6, 3D=7, 3E=8, 46=9.
- Command key map (base): 5A=Enter, 66=Backspace, 76=Esc.
- FSM states and transitions:
  - IDLE: F0 -> BRK; E0 -> EXT; any other byte is a make of a base code -> evaluate make, stay IDLE.
  - EXT: F0 -> EXT_BRK; any other byte is an extended make -> evaluate (base build: ignored), -> IDLE.
  - BRK: next byte is a base break -> evaluate break, -> IDLE.
  - EXT_BRK: next byte is an extended break -> evaluate break, -> IDLE.
- Prefix timeout:
  - In BRK, EXT and EXT_BRK, the counter increments each cycle that scancode_valid=0.
  - When the counter reaches PREFIX_TIMEOUT, go to IDLE with no event.
  - The counter clears on every valid byte and on entry to IDLE.
- Make evaluation:
  - Code is {ext flag, byte}. If held_valid=1 and the code equals the held code, it is typematic repeat: no strobe.
  - Otherwise, for a recognised key: fire its strobe, then set held code=code and held_valid=1.
  - On a digit: also update digit and set number=1<<digit.
  - Unrecognised codes produce no event and leave held state unchanged.
- Break evaluation:
  - If the code equals the held code, set held_valid=0.
  - Otherwise ignore it. No strobes are ever produced on break.
- Esc make: pulse clear_strobe and set number=0. digit is unchanged.
- Simultaneous/ordering rules:
  - Only one strobe is asserted in any cycle.
  - A new make of a different key while another key is held fires normally and replaces the held code.
- Byte arriving in the same cycle the timeout fires: the byte wins and is processed in the current prefix state.
- Reset asserted mid-sequence: the partial prefix is discarded and no strobe is issued in the following cycle.

Optional Feature:
- Macro: PS2_NUMPAD_EN
- Defined:
  - Numpad digits are accepted with the same effect as top-row digits: 70=0, 69=1, 72=2, 7A=3, 6B=4, 73=5, 74=6, 6C=7, 75=8, 7D=9.
  - Extended E0 5A (numpad Enter) produces enter_strobe.
  - Numpad 0 and top-row 0 are distinct held codes.
- Undefined:
  - These codes are unrecognised and produce no event.
  - All other extended makes are always ignored.

Test Plan:
- Bytes 1E, F0, 1E -> exactly one digit_strobe, one cycle after the first byte. digit=2, number=10'b0000000100, then held_valid falls after the final 1E.
- Bytes 3E, 3E, 3E (auto-repeat), F0, 3E, 3E -> exactly two digit_strobes with digit=8, the second one after the second break-free 3E.
- Bytes F0 and then no further byte for PREFIX_TIMEOUT cycles, followed by 45 -> 45 is treated as a make. digit_strobe fires with digit=0 and number=10'b0000000001.
- Bytes 5A, F0, 5A, 66, F0, 66, 76 -> enter_strobe, backspace_strobe and clear_strobe each fire once in that order. number=0 after the 76.
- Bytes E0, 5A -> enter_strobe when PS2_NUMPAD_EN is defined; no strobe when it is not. Bytes 7D -> digit=9 only when it is defined.
- Bytes E0 then reset=1 for 1 cycle, then F0, 16 -> the F0/16 pair is handled as a base break from IDLE. No strobes at all, and every output stays at its reset value.
